pack_station_arbiter: RTL and testbench

- Shares the single packing station (PAC actuators) between the low-sock (bajos) and high-sock (altos) production lines.
- Each line requests a batch of N pairs. The arbiter grants one line at a time, times the per-pair packing interval, and signals batch completion.
- Sits between the line FSMs and the PAC/LED drivers inside the sock-factory FSM top level.

---
 rtl/pack_station_arbiter_if.sv | 35 +++
 rtl/pack_station_arbiter.sv | 141 ++++++++++++++
 tb/tb_pack_station_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pack_station_arbiter_if.sv
// pack_station_arbiter_if
//   Handshake bundle between the production-line FSMs and the packing-station
//   arbiter.
//   Line side  : req_bajos/req_altos, cnt_bajos/cnt_altos, stop
//   Arbiter    : gnt_bajos/gnt_altos, pack_pulse, done_bajos/done_altos,
//                remaining, state
//   Modports   : master = line/controller side, slave = arbiter side.
interface pack_station_arbiter_if #(
    parameter int CNT_W = 3
);
    logic             req_bajos;
    logic             req_altos;
    logic [CNT_W-1:0] cnt_bajos;
    logic [CNT_W-1:0] cnt_altos;
    logic             stop;
    logic             gnt_bajos;
    logic             gnt_altos;
    logic             pack_pulse;
    logic             done_bajos;
    logic             done_altos;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       state;

    modport master (
        output req_bajos, req_altos, cnt_bajos, cnt_altos, stop,
        input  gnt_bajos, gnt_altos, pack_pulse, done_bajos, done_altos,
               remaining, state
    );

    modport slave (
        input  req_bajos, req_altos, cnt_bajos, cnt_altos, stop,
        output gnt_bajos, gnt_altos, pack_pulse, done_bajos, done_altos,
               remaining, state
    );
endinterface

// File: rtl/pack_station_arbiter.sv
// pack_station_arbiter
//   Shares the single packing station between the bajos (low-sock) and altos
//   (high-sock) lines. Grants one line per batch, times PACK_CYCLES clocks per
//   packed pair, pulses pack_pulse per pair and done_x at batch completion.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-low
//     bus   : pack_station_arbiter_if.slave (requests, counts, stop in;
//             grants, pack_pulse, done pulses, remaining, state out)
//   Optional feature: define PACK_FIXED_PRIORITY_EN to make bajos win every
//   tie; by default ties alternate round-robin on the last served line.
module pack_station_arbiter #(
    parameter int PACK_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    pack_station_arbiter_if.slave   bus
);
    localparam int TW = (PACK_CYCLES > 1) ? $clog2(PACK_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PACK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PACK = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        OWN_BAJOS = 1'b0,
        OWN_ALTOS = 1'b1
    } owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_q, last_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic valid_b, valid_a, pick_b, owner_req, pulse_due;

    assign valid_b = bus.req_bajos && (bus.cnt_bajos != '0);
    assign valid_a = bus.req_altos && (bus.cnt_altos != '0);

`ifdef PACK_FIXED_PRIORITY_EN
    assign pick_b = valid_b;
`else
    // bajos wins unless altos also wants it and bajos was served last
    assign pick_b = valid_b && (!valid_a || (last_q == OWN_ALTOS));
`endif

    assign owner_req = (owner_q == OWN_BAJOS) ? bus.req_bajos : bus.req_altos;
    assign pulse_due = (state_q == ST_PACK) && !bus.stop && (timer_q == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_BAJOS;
            last_q  <= OWN_ALTOS;
            timer_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.stop && (pick_b || valid_a)) begin
                    state_d = ST_PACK;
                    timer_d = '0;
                    if (pick_b) begin
                        owner_d = OWN_BAJOS;
                        rem_d   = bus.cnt_bajos;
                    end else begin
                        owner_d = OWN_ALTOS;
                        rem_d   = bus.cnt_altos;
                    end
                end
            end
            ST_PACK: begin
                if (!bus.stop) begin
                    if (pulse_due) begin
                        timer_d = '0;
                        if (rem_q <= CNT_W'(1)) begin
                            state_d = ST_DONE;
                            rem_d   = '0;
                        end else begin
                            rem_d = rem_q - 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                // Abort overrides completion; the pulse above still fires.
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    timer_d = '0;
                    last_d  = owner_q;
                end
            end
            ST_DONE: begin
                if (!bus.stop) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt_bajos  = (state_q != ST_IDLE) && (owner_q == OWN_BAJOS);
        bus.gnt_altos  = (state_q != ST_IDLE) && (owner_q == OWN_ALTOS);
        bus.pack_pulse = pulse_due;
        bus.done_bajos = (state_q == ST_DONE) && !bus.stop && (owner_q == OWN_BAJOS);
        bus.done_altos = (state_q == ST_DONE) && !bus.stop && (owner_q == OWN_ALTOS);
        bus.remaining  = rem_q;
        bus.state      = state_q;
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!reset)
        !(bus.gnt_bajos && bus.gnt_altos));
    a_pulse_in_pack: assert property (@(posedge clk) disable iff (!reset)
        bus.pack_pulse |-> (state_q == ST_PACK));
    a_done_b_gnt: assert property (@(posedge clk) disable iff (!reset)
        bus.done_bajos |-> bus.gnt_bajos);
    a_done_a_gnt: assert property (@(posedge clk) disable iff (!reset)
        bus.done_altos |-> bus.gnt_altos);
endmodule

// File: tb/tb_pack_station_arbiter.sv
// tb_pack_station_arbiter
//   Directed bench for pack_station_arbiter (PACK_CYCLES=4, CNT_W=3).
//   Inputs change at the falling edge; outputs are sampled 1 time unit later.
//   Cycle j of a scenario is the j-th falling edge after the cycle in which
//   the request was applied.
module tb_pack_station_arbiter;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PACK = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    pack_station_arbiter_if #(.CNT_W(3)) bus ();

    pack_station_arbiter #(
        .PACK_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {bus.state, bus.gnt_bajos, bus.gnt_altos, bus.pack_pulse,
                bus.done_bajos, bus.done_altos, bus.remaining};
    endfunction

    function automatic logic [9:0] ev(logic [1:0] s, logic gb, logic ga, logic p,
                                      logic db, logic da, logic [2:0] rem);
        return {s, gb, ga, p, db, da, rem};
    endfunction

    task automatic set_in(logic rb, logic [2:0] cb, logic ra, logic [2:0] ca, logic st);
        bus.req_bajos = rb;
        bus.cnt_bajos = cb;
        bus.req_altos = ra;
        bus.cnt_altos = ca;
        bus.stop      = st;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] o;
        do_reset();
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            #1;
            o = obs();
            checks++;
            if (o !== 10'b0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %b, expected %b", j, o, 10'b0);
            end
        end
    endtask

    task automatic test_single_batch();
        logic [9:0] o, e;
        logic [1:0] s;
        logic [2:0] rem;
        do_reset();
        @(negedge clk);
        set_in(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            if (j == 13) bus.req_bajos = 1'b0;
            #1;
            s   = (j <= 12) ? S_PACK : (j == 13) ? S_DONE : S_IDLE;
            rem = (j <= 12) ? 3'(3 - (j - 1) / 4) : 3'd0;
            e   = ev(s, j <= 13, 1'b0, (j == 4) || (j == 8) || (j == 12), j == 13, 1'b0, rem);
            o   = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL single_batch cycle %0d: got %b, expected %b", j, o, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] o, e;
        logic [1:0] s;
        logic ob;
        int k, p;
        do_reset();
        @(negedge clk);
        set_in(1'b1, 3'd1, 1'b1, 3'd1, 1'b0);
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            #1;
            k = (j - 1) / 6;
            p = (j - 1) % 6;
`ifdef PACK_FIXED_PRIORITY_EN
            ob = 1'b1;
`else
            ob = (k % 2 == 0);
`endif
            s = (p <= 3) ? S_PACK : (p == 4) ? S_DONE : S_IDLE;
            e = ev(s, ob && (p <= 4), !ob && (p <= 4), p == 3,
                   ob && (p == 4), !ob && (p == 4), (p <= 3) ? 3'd1 : 3'd0);
            o = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL round_robin cycle %0d: got %b, expected %b", j, o, e);
            end
            checks++;
            if (bus.gnt_bajos && bus.gnt_altos) begin
                fails++;
                $display("FAIL both_grants cycle %0d: got gnt_b=%b gnt_a=%b, expected not both 1",
                         j, bus.gnt_bajos, bus.gnt_altos);
            end
        end
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_stop();
        logic [9:0] o, e;
        logic [1:0] s;
        logic [2:0] rem;
        do_reset();
        @(negedge clk);
        set_in(1'b0, 3'd0, 1'b1, 3'd2, 1'b0);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            bus.stop = (j >= 3) && (j <= 7);
            if (j == 14) bus.req_altos = 1'b0;
            #1;
            s   = (j <= 13) ? S_PACK : (j == 14) ? S_DONE : S_IDLE;
            rem = (j <= 9) ? 3'd2 : (j <= 13) ? 3'd1 : 3'd0;
            e   = ev(s, 1'b0, j <= 14, (j == 9) || (j == 13), 1'b0, j == 14, rem);
            o   = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL stop_hold cycle %0d: got %b, expected %b", j, o, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] o, e;
        do_reset();
        @(negedge clk);
        set_in(1'b1, 3'd5, 1'b1, 3'd2, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 9) bus.req_bajos = 1'b0;
            #1;
            if (j <= 9)
                e = ev(S_PACK, 1'b1, 1'b0, (j == 4) || (j == 8), 1'b0, 1'b0,
                       (j <= 4) ? 3'd5 : (j <= 8) ? 3'd4 : 3'd3);
            else if (j == 10)
                e = ev(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            else
                e = ev(S_PACK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
            o = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL abort cycle %0d: got %b, expected %b", j, o, e);
            end
        end
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_zero_and_reset();
        logic [9:0] o, e;
        do_reset();
        @(negedge clk);
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            #1;
            o = obs();
            checks++;
            if (o !== 10'b0) begin
                fails++;
                $display("FAIL zero_count cycle %0d: got %b, expected %b", j, o, 10'b0);
            end
        end
        bus.cnt_bajos = 3'd3;
        for (int m = 1; m <= 9; m++) begin
            @(negedge clk);
            if (m == 5) reset = 1'b0;
            if (m == 8) begin
                reset = 1'b1;
                bus.req_bajos = 1'b0;
            end
            #1;
            if (m <= 5)
                e = ev(S_PACK, 1'b1, 1'b0, m == 4, 1'b0, 1'b0, (m <= 4) ? 3'd3 : 3'd2);
            else
                e = 10'b0;
            o = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL mid_reset cycle %0d: got %b, expected %b", m, o, e);
            end
        end
    endtask

    initial begin
        clk    = 1'b0;
        reset  = 1'b0;
        checks = 0;
        fails  = 0;
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        test_reset();
        test_single_batch();
        test_round_robin();
        test_stop();
        test_abort();
        test_zero_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
